alarm_ctrl: RTL
===============

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter SNOOZE_SEC, default 300, seconds between snooze press and re-ring.
REQ-002 SHALL have parameter RING_SEC, default 60, seconds of unattended ringing before auto-silence.
REQ-003 SHALL have port clk  input  1  single system clock; all flops on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port tick  input  1  one-cycle strobe, once per second.
REQ-006 SHALL have ports mode_btn, adv_btn, snooze_btn  input  1 each  raw asynchronous button levels, high = pressed.
REQ-007 SHALL have port alarm_on  input  1  alarm-enable switch level.
REQ-008 SHALL have port match  input  1  level from the alarm comparator, high while time equals alarm time.
REQ-009 SHALL have ports timeset, alarmset  output  1 each  set-mode levels to the clock datapath.
REQ-010 SHALL have ports minadv, hrsadv, dayadv  output  1 each  one-cycle advance pulses to the datapath.
REQ-011 SHALL have port buzz  output  1  alarm sounder drive.
REQ-012 SHALL have port mode  output  3  current mode-FSM state encoding.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer plus rising-edge detector; press pulse is 1 cycle and is acted on 3 clk edges after the raw rise.
REQ-014 SHALL implement mode FSM RUN(0) -> SET_TMIN(1) -> SET_THRS(2) -> SET_TDAY(3) -> SET_AMIN(4) -> SET_AHRS(5) -> RUN, advancing one state per mode press; encodings 6-7 SHALL return to RUN.
REQ-015 SHALL drive timeset=1 exactly in states 1-3 and alarmset=1 exactly in states 4-5, registered outputs.
REQ-016 SHALL convert an adv press into a single-cycle pulse: minadv in SET_TMIN/SET_AMIN, hrsadv in SET_THRS/SET_AHRS, dayadv in SET_TDAY; adv press in RUN SHALL be ignored.
REQ-017 SHALL never assert more than one of minadv/hrsadv/dayadv in a cycle, and none in a cycle where mode changes.
REQ-018 SHALL implement ring FSM IDLE, RING, SNOOZE; buzz=1 only in RING.
REQ-019 SHALL go IDLE -> RING on a rising edge of match while alarm_on=1 and mode=RUN, clearing the ring counter; match edges in RING/SNOOZE SHALL be ignored.
REQ-020 SHALL in RING increment the ring counter on tick and go to IDLE when it reaches RING_SEC.
REQ-021 SHALL on snooze press in RING load the snooze counter with SNOOZE_SEC and enter SNOOZE; snooze press in IDLE/SNOOZE is ignored.
REQ-022 SHALL in SNOOZE decrement on tick and enter RING with ring counter cleared when the count reaches 0.
REQ-023 SHALL force ring FSM to IDLE on the cycle after alarm_on is sampled low, from any state.
REQ-024 SHALL treat a mode press in RING or SNOOZE as dismiss: ring FSM -> IDLE, mode FSM unchanged (press consumed).
REQ-025 SHALL resolve simultaneous events: mode press over snooze press; snooze press over tick (counter loaded, not decremented); alarm_on low over all.
REQ-026 SHALL size counters as clog2(max(SNOOZE_SEC,RING_SEC)+1) bits with no wrap past terminal values.

Reset
REQ-027 SHALL on rst low asynchronously set mode=RUN, ring=IDLE, counters=0, all outputs 0.
REQ-028 SHALL reset synchronizer/edge flops and the match-history flop to 1 so a button held or match present through reset produces no event.
REQ-029 SHALL abort any ring or snooze in progress when reset asserts mid-operation.

Structure
REQ-030 SHALL place mode_t and ring_t enums and default SNOOZE_SEC/RING_SEC constants in shared package clock_pkg.
REQ-031 SHALL implement synchronizer/edge detect as sub-module btn_sync, instantiated once per button.

Verification
REQ-032 SHALL cover: 6 mode presses from reset -> mode 1,2,3,4,5,0; timeset high for 1-3, alarmset for 4-5.
REQ-033 SHALL cover: SET_THRS, 3 adv presses -> exactly 3 single-cycle hrsadv pulses, no minadv/dayadv.
REQ-034 SHALL cover: RING_SEC=5, match rise with alarm_on=1 -> buzz=1 for exactly 5 ticks, then IDLE.
REQ-035 SHALL cover: SNOOZE_SEC=3, snooze press while ringing -> buzz 0 for 3 ticks, then buzz 1 again.
REQ-036 SHALL cover: snooze and mode press same cycle while ringing -> IDLE, mode unchanged; alarm_on drop in SNOOZE -> IDLE next cycle.
REQ-037 SHALL cover: rst low with buttons and match held high, release -> no mode change, buzz stays 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the alarm controller.
// Mode and ring state encodings live here so datapath and tests agree.
package clock_pkg;

  localparam int SNOOZE_SEC_DEF = 300;
  localparam int RING_SEC_DEF   = 60;

  typedef enum logic [2:0] {
    M_RUN  = 3'd0,
    M_TMIN = 3'd1,
    M_THRS = 3'd2,
    M_TDAY = 3'd3,
    M_AMIN = 3'd4,
    M_AHRS = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_RING   = 2'd1,
    R_SNOOZE = 2'd2
  } ring_t;

endpackage

// File: rtl/btn_sync.sv
// Button synchronizer and rising-edge detector.
// Ports: clk, rst (async active-low), raw level in, press 1-cycle pulse out.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic s1_q, s2_q, prev_q;

  // Reset high so a button held through reset gives no edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign press = s2_q & ~prev_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock control: mode/set FSM, advance pulses, ring/snooze FSM.
// Ports: clk, rst, tick, buttons, alarm_on, match in; set levels,
// advance pulses, buzz and mode encoding out.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int RING_SEC   = RING_SEC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       adv_btn,
  input  logic       snooze_btn,
  input  logic       alarm_on,
  input  logic       match,
  output logic       timeset,
  output logic       alarmset,
  output logic       minadv,
  output logic       hrsadv,
  output logic       dayadv,
  output logic       buzz,
  output logic [2:0] mode
);

  localparam int CMAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RING_LIM = CW'(RING_SEC);
  localparam logic [CW-1:0] SNZ_LD   = CW'(SNOOZE_SEC);

  logic mode_p, adv_p, snz_p;

  btn_sync u_mode (.clk(clk), .rst(rst), .raw(mode_btn),   .press(mode_p));
  btn_sync u_adv  (.clk(clk), .rst(rst), .raw(adv_btn),    .press(adv_p));
  btn_sync u_snz  (.clk(clk), .rst(rst), .raw(snooze_btn), .press(snz_p));

  mode_t         mode_q, mode_d;
  ring_t         ring_q, ring_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          match_q;
  logic          ts_q, ts_d, as_q, as_d;
  logic          min_q, min_d, hrs_q, hrs_d, day_q, day_d;

  logic          dismiss, step, adv_ok;
  logic [CW-1:0] rcnt_nx;

  // A mode press while the alarm is active only silences it.
  assign dismiss = mode_p & (ring_q != R_IDLE);
  assign step    = mode_p & ~dismiss;
  assign adv_ok  = adv_p & ~mode_p;
  assign rcnt_nx = rcnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= M_RUN;
      ring_q  <= R_IDLE;
      rcnt_q  <= '0;
      scnt_q  <= '0;
      match_q <= 1'b1;
      ts_q    <= 1'b0;
      as_q    <= 1'b0;
      min_q   <= 1'b0;
      hrs_q   <= 1'b0;
      day_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      ring_q  <= ring_d;
      rcnt_q  <= rcnt_d;
      scnt_q  <= scnt_d;
      match_q <= match;
      ts_q    <= ts_d;
      as_q    <= as_d;
      min_q   <= min_d;
      hrs_q   <= hrs_d;
      day_q   <= day_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      M_RUN:   if (step) mode_d = M_TMIN;
      M_TMIN:  if (step) mode_d = M_THRS;
      M_THRS:  if (step) mode_d = M_TDAY;
      M_TDAY:  if (step) mode_d = M_AMIN;
      M_AMIN:  if (step) mode_d = M_AHRS;
      M_AHRS:  if (step) mode_d = M_RUN;
      default: mode_d = M_RUN;
    endcase
  end

  // Levels follow the next state so they line up with mode_q.
  always_comb begin
    ts_d  = (mode_d == M_TMIN) | (mode_d == M_THRS) | (mode_d == M_TDAY);
    as_d  = (mode_d == M_AMIN) | (mode_d == M_AHRS);
    min_d = adv_ok & ((mode_q == M_TMIN) | (mode_q == M_AMIN));
    hrs_d = adv_ok & ((mode_q == M_THRS) | (mode_q == M_AHRS));
    day_d = adv_ok & (mode_q == M_TDAY);
  end

  always_comb begin
    ring_d = ring_q;
    rcnt_d = rcnt_q;
    scnt_d = scnt_q;
    if (!alarm_on) begin
      ring_d = R_IDLE;
      rcnt_d = '0;
      scnt_d = '0;
    end else begin
      unique case (ring_q)
        R_IDLE: begin
          if (match && !match_q && mode_q == M_RUN) begin
            ring_d = R_RING;
            rcnt_d = '0;
          end
        end
        R_RING: begin
          if (mode_p) begin
            ring_d = R_IDLE;
          end else if (snz_p) begin
            ring_d = R_SNOOZE;
            scnt_d = SNZ_LD;
          end else if (tick && rcnt_q != RING_LIM) begin
            rcnt_d = rcnt_nx;
            if (rcnt_nx == RING_LIM) ring_d = R_IDLE;
          end
        end
        R_SNOOZE: begin
          if (mode_p) begin
            ring_d = R_IDLE;
          end else if (tick) begin
            if (scnt_q <= CW'(1)) begin
              ring_d = R_RING;
              rcnt_d = '0;
              scnt_d = '0;
            end else begin
              scnt_d = scnt_q - CW'(1);
            end
          end
        end
        default: ring_d = R_IDLE;
      endcase
    end
  end

  assign timeset  = ts_q;
  assign alarmset = as_q;
  assign minadv   = min_q;
  assign hrsadv   = hrs_q;
  assign dayadv   = day_q;
  assign buzz     = (ring_q == R_RING);
  assign mode     = mode_q;

endmodule
